seven_seg_rx: RTL and testbench

SEVEN_SEG_RX -- requirements
Module: seven_seg_rx

---
 rtl/seven_seg_rx_pkg.sv | 37 +++
 rtl/seven_seg_hex_decode.sv | 39 +++
 rtl/seven_seg_rx.sv | 144 ++++++++++++++
 tb/tb_seven_seg_rx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_rx_pkg.sv
// seven_seg_rx_pkg
// Constants and types shared between the seven-segment receiver and the
// display-driver side of the bus.
//   - rx_state_t      : receiver pairing FSM state
//   - SEG_0 .. SEG_F  : active-high segment patterns (bit0 = a .. bit6 = g)
//   - SEG_BLANK       : all segments off
//   - BUS_IDLE        : bus value used as the reset/idle history
package seven_seg_rx_pkg;

  typedef enum logic [0:0] {
    HUNT     = 1'b0,
    HAVE_LSB = 1'b1
  } rx_state_t;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-low segments all off, LSB digit selected.
  localparam logic [7:0] BUS_IDLE = 8'hFF;

endpackage

// File: rtl/seven_seg_hex_decode.sv
// seven_seg_hex_decode
// Combinational hex decoder for active-high seven-segment patterns.
// Ports:
//   seg    in  [6:0] active-high segments (bit0 = a .. bit6 = g)
//   nibble out [3:0] decoded hex digit (0 when not a table pattern)
//   hit    out       1 when seg matches one of the 16 hex patterns
module seven_seg_hex_decode
  import seven_seg_rx_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b1;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_rx.sv
// seven_seg_rx
// Receives a multiplexed two-digit seven-segment display bus and recovers
// the displayed byte. The bus is synchronized, debounced (a word must stay
// unchanged for STABLE_CYCLES samples and is taken once per stable episode),
// decoded, and paired LSB-then-MSB into dout.
// Parameters:
//   STABLE_CYCLES  consecutive identical samples needed to accept a word (2..255)
// Ports:
//   CLK      in       clock, rising edge
//   RST      in       asynchronous active-high reset
//   din      in  [7:0] [6:0] active-low segments a..g, [7] 1=LSB digit 0=MSB digit
//   dout     out [7:0] last captured value {MSB nibble, LSB nibble}
//   valid    out      one-cycle pulse when dout is updated
//   err      out      one-cycle pulse when an accepted word is undecodable
//   err_cnt  out [7:0] saturating count of err pulses
// Build option:
//   SEVEN_SEG_RX_ERR_CNT_EN  when defined, err_cnt counts err pulses;
//                            otherwise err_cnt is tied to 8'h00.
module seven_seg_rx
  import seven_seg_rx_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       valid,
  output logic       err,
  output logic [7:0] err_cnt
);

  // The count register holds samples seen minus one at the point of decision.
  localparam logic [7:0] ACCEPT_AT = 8'(STABLE_CYCLES - 1);

  logic [7:0] sync_p0;
  logic [7:0] sync_p1;
  logic [7:0] hist_p2;
  logic [7:0] stab_cnt;
  logic       consumed;
  logic [7:0] acc_word_p3;
  logic       vld_p3;

  logic [3:0] dec_nibble;
  logic       dec_hit;
  logic       dec_blank;
  logic       bad_word;

  rx_state_t  state;
  logic [3:0] lsb_nib;

  // Stage p0/p1: two-flop synchronizer on the whole bus.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_p0 <= BUS_IDLE;
      sync_p1 <= BUS_IDLE;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2 -> p3: stability filter. The history starts "consumed" so the
  // idle bus after reset is never taken as a word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hist_p2     <= BUS_IDLE;
      stab_cnt    <= 8'd0;
      consumed    <= 1'b1;
      acc_word_p3 <= BUS_IDLE;
      vld_p3      <= 1'b0;
    end else begin
      vld_p3 <= 1'b0;
      if (sync_p1 != hist_p2) begin
        hist_p2  <= sync_p1;
        stab_cnt <= 8'd1;
        consumed <= 1'b0;
      end else if (!consumed) begin
        if (stab_cnt == ACCEPT_AT) begin
          acc_word_p3 <= hist_p2;
          vld_p3      <= 1'b1;
          consumed    <= 1'b1;
        end else begin
          stab_cnt <= stab_cnt + 8'd1;
        end
      end
    end
  end

  // Stage p3: decode the accepted word (bus segments are active-low).
  seven_seg_hex_decode u_decode (
    .seg    (~acc_word_p3[6:0]),
    .nibble (dec_nibble),
    .hit    (dec_hit)
  );

  assign dec_blank = (~acc_word_p3[6:0] == SEG_BLANK);
  assign bad_word  = vld_p3 && !dec_blank && !dec_hit;

  // Stage p3 -> outputs: LSB/MSB pairing FSM. Blank words change nothing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= HUNT;
      lsb_nib <= 4'h0;
      dout    <= 8'h00;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (bad_word) begin
        err   <= 1'b1;
        state <= HUNT;
      end else if (vld_p3 && !dec_blank) begin
        if (acc_word_p3[7]) begin
          lsb_nib <= dec_nibble;
          state   <= HAVE_LSB;
        end else if (state == HAVE_LSB) begin
          dout  <= {dec_nibble, lsb_nib};
          valid <= 1'b1;
          state <= HUNT;
        end
      end
    end
  end

`ifdef SEVEN_SEG_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Counts alongside the err pulse; holds at 8'hFF.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_cnt_q <= 8'h00;
    end else if (bad_word && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_seven_seg_rx.sv
module tb_seven_seg_rx;

  localparam int S = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] din = 8'hFF;
  logic [7:0] dout;
  logic       valid;
  logic       err;
  logic [7:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  int valid_seen = 0;
  int err_seen   = 0;
  int both_seen  = 0;
  logic [8:0] obs_q[$];

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_seg_rx #(.STABLE_CYCLES(S)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .din     (din),
    .dout    (dout),
    .valid   (valid),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 CLK = ~CLK;

  // Output events observed on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (valid && err) both_seen++;
    if (valid) begin
      valid_seen++;
      obs_q.push_back({1'b0, dout});
    end
    if (err) begin
      err_seen++;
      obs_q.push_back({1'b1, 8'h00});
    end
  end

  // Reference decode: {hit, nibble} for an active-low bus word.
  function automatic logic [4:0] ref_decode(input logic [7:0] w);
    logic [6:0] seg;
    ref_decode = 5'h00;
    seg = ~w[6:0];
    for (int i = 0; i < 16; i++)
      if (tbl[i] == seg) ref_decode = {1'b1, 4'(i)};
  endfunction

  function automatic logic [7:0] rand_word();
    logic [6:0] seg;
    logic       sel;
    int         kind;
    sel  = 1'($urandom_range(0, 1));
    kind = $urandom_range(0, 7);
    if (kind <= 5) begin
      seg = tbl[$urandom_range(0, 15)];
    end else if (kind == 6) begin
      seg = 7'h00;
    end else begin
      seg = 7'($urandom_range(1, 127));
      while (ref_decode({1'b0, ~seg})[4]) seg = 7'($urandom_range(1, 127));
    end
    rand_word = {sel, ~seg};
  endfunction

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic hold(input logic [7:0] v, input int n);
    din = v;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clear_mon();
    valid_seen = 0;
    err_seen   = 0;
    both_seen  = 0;
    obs_q.delete();
  endtask

  task automatic apply_reset();
    din = 8'hFF;
    RST = 1'b1;
    hold(8'hFF, 3);
    RST = 1'b0;
    hold(8'hFF, 2);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    hold(8'hF8, 8);
    hold(8'h19, 8);
    RST = 1'b1;
    #1;
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_async_dout got=%h exp=00", dout); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (err_cnt !== 8'h00) begin failures++; $display("FAIL reset_err_cnt got=%h exp=00", err_cnt); end
    for (int i = 0; i < 6; i++) hold(8'($urandom), 1);
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_hold_dout got=%h exp=00", dout); end
    din = 8'hFF;
    hold(8'hFF, 3);
    RST = 1'b0;
    clear_mon();
    hold(8'hFF, 12);
    checks++; if (valid_seen + err_seen != 0) begin failures++; $display("FAIL reset_no_capture got=%0d exp=0", valid_seen + err_seen); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_release_dout got=%h exp=00", dout); end
  endtask

  task automatic test_basic_capture();
    int k;
    clear_mon();
    hold(8'hF8, 8);
    din = 8'h19;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      k++;
      @(negedge CLK);
      if (valid) break;
    end
    @(posedge CLK);
    #1;
    hold(8'h19, 4);
    checks++; if (k - 1 != S + 2) begin failures++; $display("FAIL capture_latency got=%0d exp=%0d", k - 1, S + 2); end
    checks++; if (valid_seen != 1) begin failures++; $display("FAIL capture_valid_count got=%0d exp=1", valid_seen); end
    checks++; if (dout !== 8'h47) begin failures++; $display("FAIL capture_dout got=%h exp=47", dout); end
  endtask

  task automatic test_short_lsb();
    hold(8'hFF, 8);
    clear_mon();
    hold(8'hF8, S - 2);
    hold(8'h19, 8);
    checks++; if (valid_seen != 0) begin failures++; $display("FAIL short_lsb_valid got=%0d exp=0", valid_seen); end
    checks++; if (dout !== 8'h47) begin failures++; $display("FAIL short_lsb_dout got=%h exp=47", dout); end
  endtask

  task automatic test_msb_first();
    apply_reset();
    clear_mon();
    hold(8'h19, 8);
    checks++; if (valid_seen != 0) begin failures++; $display("FAIL msb_first_ignored got=%0d exp=0", valid_seen); end
    hold(8'hF8, 8);
    hold(8'h19, 8);
    checks++; if (valid_seen != 1) begin failures++; $display("FAIL msb_first_valid_count got=%0d exp=1", valid_seen); end
    checks++; if (dout !== 8'h47) begin failures++; $display("FAIL msb_first_dout got=%h exp=47", dout); end
  endtask

  task automatic test_invalid();
    apply_reset();
    hold(8'hF8, 8);
    clear_mon();
    hold(8'hFE, 8);
    checks++; if (err_seen != 1) begin failures++; $display("FAIL invalid_err_pulse got=%0d exp=1", err_seen); end
    checks++; if (valid_seen != 0) begin failures++; $display("FAIL invalid_no_valid got=%0d exp=0", valid_seen); end
    hold(8'h19, 8);
    checks++; if (valid_seen != 0) begin failures++; $display("FAIL invalid_returns_hunt got=%0d exp=0", valid_seen); end
    hold(8'hFF, 8);
    checks++; if (err_seen != 1) begin failures++; $display("FAIL blank_no_err got=%0d exp=1", err_seen); end
  endtask

  task automatic test_reset_mid_pair();
    apply_reset();
    hold(8'hF8, 8);
    apply_reset();
    clear_mon();
    hold(8'h19, 8);
    checks++; if (valid_seen != 0) begin failures++; $display("FAIL mid_pair_lsb_discarded got=%0d exp=0", valid_seen); end
    hold(8'hF8, 8);
    hold(8'h19, 8);
    checks++; if (valid_seen != 1 || dout !== 8'h47) begin
      failures++; $display("FAIL mid_pair_fresh_capture got=%0d/%h exp=1/47", valid_seen, dout);
    end
  endtask

  task automatic test_random();
    logic [8:0] exp_q[$];
    logic [7:0] prev, v, mdout;
    logic [4:0] d;
    logic [3:0] lsb;
    bit         have;
    int         len, n;
    apply_reset();
    clear_mon();
    prev = 8'hFF; mdout = 8'h00; lsb = 4'h0; have = 0;
    for (int s = 0; s < 60; s++) begin
      v = rand_word();
      while (v == prev) v = rand_word();
      len = $urandom_range(1, 8);
      if (s == 59) len = len + 12;
      hold(v, len);
      prev = v;
      if (len >= S && v[6:0] != 7'h7F) begin
        d = ref_decode(v);
        if (!d[4]) begin
          exp_q.push_back({1'b1, 8'h00});
          have = 0;
        end else if (v[7]) begin
          lsb = d[3:0];
          have = 1;
        end else if (have) begin
          mdout = {d[3:0], lsb};
          exp_q.push_back({1'b0, mdout});
          have = 0;
        end
      end
    end
    checks++; if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL random_event_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL random_event[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++; if (dout !== mdout) begin failures++; $display("FAIL random_final_dout got=%h exp=%h", dout, mdout); end
    checks++; if (both_seen != 0) begin failures++; $display("FAIL random_valid_err_overlap got=%0d exp=0", both_seen); end
  endtask

  task automatic test_err_cnt();
    logic [7:0] exp_cnt;
    apply_reset();
    clear_mon();
    for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 8'hFE : 8'hFD, S + 1);
    hold(8'hFF, 6);
`ifdef SEVEN_SEG_RX_ERR_CNT_EN
    exp_cnt = 8'hFF;
`else
    exp_cnt = 8'h00;
`endif
    checks++; if (err_seen != 300) begin failures++; $display("FAIL err_cnt_pulses got=%0d exp=300", err_seen); end
    checks++; if (err_cnt !== exp_cnt) begin failures++; $display("FAIL err_cnt_value got=%h exp=%h", err_cnt, exp_cnt); end
    checks++; if (valid_seen != 0) begin failures++; $display("FAIL err_cnt_no_valid got=%0d exp=0", valid_seen); end
  endtask

  initial begin
    RST = 1'b1;
    din = 8'hFF;
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    test_basic_capture();
    test_short_lsb();
    test_msb_first();
    test_invalid();
    test_reset_mid_pair();
    test_random();
    test_err_cnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
